id_stage: RTL
=============

ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 SHALL have parameter NOP_INST, default 32'h0000_0033, the instruction substituted on flush/bubble.
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port fs_to_ds_valid  input  1  fetch stage holds a valid instruction.
REQ-005 SHALL have port if_id_bus_in  input  64  {inst[63:32], pc[31:0]} from fetch.
REQ-006 SHALL have port exception_code_fd  input  6  fetch exception code, bit5 = exception present.
REQ-007 SHALL have port ds_allowin  output  1  decode can accept a new instruction this cycle.
REQ-008 SHALL have port es_allowin  input  1  execute stage can accept.
REQ-009 SHALL have port ds_to_es_valid  output  1  id_ex_bus_out valid toward execute.
REQ-010 SHALL have port id_ex_bus_out  output  150  {exc[149:144], opcode[143:137], funct3[136:134], funct7b5[133], rd[132:128], rs2_val[127:96], rs1_val[95:64], imm[63:32], pc[31:0]}.
REQ-011 SHALL have port br_flush  input  1  taken branch/jump resolved in execute; kill decode contents.
REQ-012 SHALL have ports es_valid, es_mem_read (input 1 each) and es_rd (input 5): instruction currently in execute.
REQ-013 SHALL have ports wb_we (input 1), wb_rd (input 5), wb_wdata (input 32): register write-back.
REQ-014 SHALL have port stall_flag  output  1  load-use stall active.

Function
REQ-015 SHALL hold ds_valid, ds_inst[31:0], ds_pc[31:0], ds_exc[5:0] registers; capture all when ds_allowin && fs_to_ds_valid && !br_flush.
REQ-016 SHALL set ds_valid <= fs_to_ds_valid && !br_flush whenever ds_allowin; otherwise ds_valid <= 0 if br_flush, else hold.
REQ-017 SHALL compute ds_ready_go = !stall_flag; ds_allowin = !ds_valid || (ds_ready_go && es_allowin); ds_to_es_valid = ds_valid && ds_ready_go && !br_flush.
REQ-018 SHALL assert stall_flag when ds_valid && es_valid && es_mem_read && es_rd != 0 && ((rs1 used && es_rd == rs1) || (rs2 used && es_rd == rs2)); rs1 used for all opcodes except LUI/AUIPC/JAL; rs2 used for R, S, B types only.
REQ-019 SHALL contain a 32x32 register file, written on clk when wb_we && wb_rd != 0; x0 always reads 0; register contents not reset.
REQ-020 SHALL bypass write-back: same-cycle read of wb_rd (non-zero) with wb_we returns wb_wdata.
REQ-021 SHALL generate imm combinationally: I = sext inst[31:20]; S = sext {inst[31:25],inst[11:7]}; B = sext {inst[31],inst[7],inst[30:25],inst[11:8],1'b0}; U = {inst[31:12],12'b0}; J = sext {inst[31],inst[19:12],inst[20],inst[30:21],1'b0}; R and unknown = 0.
REQ-022 SHALL pass ds_exc unchanged when ds_exc[5]=1; else set exc = 6'b100010 for opcode not in {LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, SYSTEM, MISC-MEM}; else 6'b000000.
REQ-023 SHALL drive opcode/funct3/funct7b5/rd from ds_inst; rd forced to 0 for S, B and exception-flagged instructions.
REQ-024 SHALL, when br_flush=1, output ds_to_es_valid=0 that cycle and leave decode empty next cycle regardless of fs_to_ds_valid.
REQ-025 SHALL present id_ex_bus_out built from NOP_INST (all fields decoded from it, pc = ds_pc) whenever ds_valid=0.
REQ-026 SHALL have zero added latency: a captured instruction is offered to execute the cycle after capture unless stalled.

Reset
REQ-027 SHALL, while rst_n=0 (asynchronous), clear ds_valid, ds_pc, ds_exc to 0 and load ds_inst with NOP_INST; hence ds_allowin=1, ds_to_es_valid=0, stall_flag=0.
REQ-028 SHALL resume capture on the first rising edge after rst_n deasserts; reset mid-stall discards the held instruction.

Verification
REQ-029 SHALL cover: fetch ADDI x1,x0,5 (32'h0050_0093) pc=0x10 -> next cycle ds_to_es_valid=1, imm=5, rd=1, rs1_val=0, opcode=7'h13.
REQ-030 SHALL cover: execute holds LW rd=x3, decode holds ADD x4,x3,x2 -> stall_flag=1, ds_allowin=0, ds_to_es_valid=0 for one cycle; clears when es_valid drops.
REQ-031 SHALL cover: wb_we=1 wb_rd=5 wb_wdata=0xDEADBEEF same cycle decode reads x5 -> rs1_val=0xDEADBEEF; write to x0 -> x0 reads 0.
REQ-032 SHALL cover: br_flush=1 with ds_valid=1 and fs_to_ds_valid=1 -> ds_to_es_valid=0 that cycle, ds_valid=0 next cycle.
REQ-033 SHALL cover: es_allowin=0 for 3 cycles -> id_ex_bus_out stable, ds_allowin=0; illegal opcode 7'h7F -> exc=6'b100010; incoming exception_code_fd=6'b100000 preserved.
REQ-034 SHALL cover: rst_n asserted mid-stall -> ds_valid=0 and ds_allowin=1 immediately, before next clock edge.

Source files
------------

// File: rtl/id_stage_if.sv
// Fetch->decode->execute handshake, hazard sideband and write-back port of the decode stage.
// The decode stage sits on the slave modport; the surrounding pipeline (or a bench) drives the master side.
interface id_stage_if;
  logic         fs_to_ds_valid;
  logic [63:0]  if_id_bus_in;
  logic [5:0]   exception_code_fd;
  logic         ds_allowin;
  logic         es_allowin;
  logic         ds_to_es_valid;
  logic [149:0] id_ex_bus_out;
  logic         br_flush;
  logic         es_valid;
  logic         es_mem_read;
  logic [4:0]   es_rd;
  logic         wb_we;
  logic [4:0]   wb_rd;
  logic [31:0]  wb_wdata;
  logic         stall_flag;

  modport master (
    output fs_to_ds_valid, if_id_bus_in, exception_code_fd, es_allowin, br_flush,
           es_valid, es_mem_read, es_rd, wb_we, wb_rd, wb_wdata,
    input  ds_allowin, ds_to_es_valid, id_ex_bus_out, stall_flag
  );

  modport slave (
    input  fs_to_ds_valid, if_id_bus_in, exception_code_fd, es_allowin, br_flush,
           es_valid, es_mem_read, es_rd, wb_we, wb_rd, wb_wdata,
    output ds_allowin, ds_to_es_valid, id_ex_bus_out, stall_flag
  );
endinterface

// File: rtl/id_stage.sv
// RV32 decode stage: one register slot, regfile read with write-back bypass, load-use stall.
// Offers a captured instruction to execute the next cycle; holds while execute refuses or a load-use stall is active.
module id_stage #(
  parameter logic [31:0] NOP_INST = 32'h0000_0033
) (
  input  logic       clk,
  input  logic       rst_n,
  id_stage_if.slave  bus
);

  localparam logic [6:0] OPC_LUI     = 7'h37;
  localparam logic [6:0] OPC_AUIPC   = 7'h17;
  localparam logic [6:0] OPC_JAL     = 7'h6F;
  localparam logic [6:0] OPC_JALR    = 7'h67;
  localparam logic [6:0] OPC_BRANCH  = 7'h63;
  localparam logic [6:0] OPC_LOAD    = 7'h03;
  localparam logic [6:0] OPC_STORE   = 7'h23;
  localparam logic [6:0] OPC_OPIMM   = 7'h13;
  localparam logic [6:0] OPC_OP      = 7'h33;
  localparam logic [6:0] OPC_SYSTEM  = 7'h73;
  localparam logic [6:0] OPC_MISCMEM = 7'h0F;

  logic        ds_valid_q, ds_valid_d;
  logic [31:0] ds_inst_q, ds_inst_d;
  logic [31:0] ds_pc_q, ds_pc_d;
  logic [5:0]  ds_exc_q, ds_exc_d;
  logic [31:0] rf_q [32];

  logic        ds_allowin, ds_ready_go, stall;
  logic [31:0] inst, imm, rs1_val, rs2_val;
  logic [6:0]  opcode;
  logic [4:0]  rs1, rs2, rd_out;
  logic [5:0]  exc_out;
  logic        legal, rs1_used, rs2_used, no_rd;

  // An empty slot still presents a fully decoded bubble built from NOP_INST.
  assign inst   = ds_valid_q ? ds_inst_q : NOP_INST;
  assign opcode = inst[6:0];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];

  always_comb begin
    legal    = 1'b1;
    rs1_used = 1'b1;
    rs2_used = 1'b0;
    no_rd    = 1'b0;
    imm      = 32'd0;
    case (opcode)
      OPC_LUI, OPC_AUIPC: begin
        imm      = {inst[31:12], 12'd0};
        rs1_used = 1'b0;
      end
      OPC_JAL: begin
        imm      = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
        rs1_used = 1'b0;
      end
      OPC_JALR, OPC_LOAD, OPC_OPIMM, OPC_SYSTEM, OPC_MISCMEM: begin
        imm = {{20{inst[31]}}, inst[31:20]};
      end
      OPC_STORE: begin
        imm      = {{20{inst[31]}}, inst[31:25], inst[11:7]};
        rs2_used = 1'b1;
        no_rd    = 1'b1;
      end
      OPC_BRANCH: begin
        imm      = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
        rs2_used = 1'b1;
        no_rd    = 1'b1;
      end
      OPC_OP: begin
        rs2_used = 1'b1;
      end
      default: begin
        legal = 1'b0;
      end
    endcase
  end

  // A fetch-side exception takes priority over the illegal-opcode code.
  assign exc_out = (ds_valid_q && ds_exc_q[5]) ? ds_exc_q :
                   (legal ? 6'b000000 : 6'b100010);
  assign rd_out  = (no_rd || exc_out[5]) ? 5'd0 : inst[11:7];

  assign rs1_val = (rs1 == 5'd0) ? 32'd0 :
                   (bus.wb_we && bus.wb_rd == rs1) ? bus.wb_wdata : rf_q[rs1];
  assign rs2_val = (rs2 == 5'd0) ? 32'd0 :
                   (bus.wb_we && bus.wb_rd == rs2) ? bus.wb_wdata : rf_q[rs2];

  assign stall = ds_valid_q && bus.es_valid && bus.es_mem_read && (bus.es_rd != 5'd0) &&
                 ((rs1_used && bus.es_rd == rs1) || (rs2_used && bus.es_rd == rs2));

  assign ds_ready_go        = !stall;
  assign ds_allowin         = !ds_valid_q || (ds_ready_go && bus.es_allowin);
  assign bus.ds_allowin     = ds_allowin;
  assign bus.ds_to_es_valid = ds_valid_q && ds_ready_go && !bus.br_flush;
  assign bus.stall_flag     = stall;
  assign bus.id_ex_bus_out  = {exc_out, opcode, inst[14:12], inst[30], rd_out,
                               rs2_val, rs1_val, imm, ds_pc_q};

  always_comb begin
    ds_valid_d = ds_valid_q;
    ds_inst_d  = ds_inst_q;
    ds_pc_d    = ds_pc_q;
    ds_exc_d   = ds_exc_q;
    if (ds_allowin) begin
      ds_valid_d = bus.fs_to_ds_valid && !bus.br_flush;
    end else if (bus.br_flush) begin
      ds_valid_d = 1'b0;
    end
    if (ds_allowin && bus.fs_to_ds_valid && !bus.br_flush) begin
      ds_inst_d = bus.if_id_bus_in[63:32];
      ds_pc_d   = bus.if_id_bus_in[31:0];
      ds_exc_d  = bus.exception_code_fd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ds_valid_q <= 1'b0;
      ds_inst_q  <= NOP_INST;
      ds_pc_q    <= 32'd0;
      ds_exc_q   <= 6'd0;
    end else begin
      ds_valid_q <= ds_valid_d;
      ds_inst_q  <= ds_inst_d;
      ds_pc_q    <= ds_pc_d;
      ds_exc_q   <= ds_exc_d;
    end
  end

  // Register contents survive reset; x0 is never written and reads as zero above.
  always_ff @(posedge clk) begin
    if (bus.wb_we && bus.wb_rd != 5'd0) begin
      rf_q[bus.wb_rd] <= bus.wb_wdata;
    end
  end

endmodule
